johnson_seq_checker: RTL and testbench

Serial sequence checker for the 2·WIDTH-state twisted-ring (Johnson) pattern that the `dfftop` shift-register generator produces. The stream is taken from the generator's last stage, which repeats WIDTH zeros then WIDTH ones. The block self-synchronises using the rule `din(t) = ~din(t-WIDTH)`, so it needs no seed or phase alignment. It then reports lock status and counts bit errors, and sits at the receiving end of the generator link as its loopback/BIST checker.

---
 rtl/johnson_seq_checker.sv | 160 ++++++++++++++++
 tb/tb_johnson_seq_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_checker.sv
// -----------------------------------------------------------------------------
// johnson_seq_checker
//
// Serial checker for the twisted-ring (Johnson) stream taken from the last
// stage of a WIDTH-stage generator: WIDTH zeros, then WIDTH ones, repeated.
// The checker needs no seed or phase alignment. It uses the rule
// din(t) = ~din(t-WIDTH), so it locks onto either polarity of the stream.
// It reports lock status and counts bit errors seen while locked.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   din_valid  in   din is sampled only when high
//   din        in   serial bit from the generator's last stage
//   clr_cnt    in   synchronous clear of err_cnt (wins over an increment)
//   locked     out  checker is in the LOCKED state (registered)
//   err        out  one-cycle pulse per mismatch seen while locked (registered)
//   err_cnt    out  saturating count of mismatches seen while locked
// -----------------------------------------------------------------------------
module johnson_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_ERR + 1);

  // Counter values that complete a phase on the bit currently being sampled.
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERR - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [FW-1:0]      fill_cnt_q, fill_cnt_d;
  logic [GW-1:0]      good_cnt_q, good_cnt_d;
  logic [BW-1:0]      bad_cnt_q, bad_cnt_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               mismatch;

  // hist_q[WIDTH-1] is the bit sampled WIDTH valid bits ago; the incoming bit
  // should be its complement, so equality is an error.
  assign mismatch = (din == hist_q[WIDTH-1]);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: hist is reset along with the counters even though FILL overwrites it
  // before any comparison; this keeps the post-reset state fully defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      hist_q     <= '0;
      fill_cnt_q <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_cnt_q <= fill_cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Nothing moves unless a valid bit is present.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: hold values assigned first so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    hist_d     = hist_q;
    fill_cnt_d = fill_cnt_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;

    if (din_valid) begin
      hist_d = {hist_q[WIDTH-2:0], din};
      unique case (state_q)
        ST_FILL: begin
          fill_cnt_d = fill_cnt_q + FW'(1);
          if (fill_cnt_q == FILL_LAST) begin
            state_d    = ST_SYNC;
            good_cnt_d = '0;
          end
        end
        ST_SYNC: begin
          if (mismatch) begin
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_q == GOOD_LAST) begin
              state_d   = ST_LOCKED;
              bad_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            bad_cnt_d = bad_cnt_q + BW'(1);
            if (bad_cnt_q == BAD_LAST) begin
              state_d    = ST_SYNC;
              good_cnt_d = '0;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic. Outputs are computed from the next state / current sample
  // and registered, so they change on the edge that samples the deciding bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_d  = (state_d == ST_LOCKED);
    err_d     = din_valid && (state_q == ST_LOCKED) && mismatch;
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_checker
//
// Scoreboard bench: the driver computes the expected post-edge outputs from a
// behavioural model (bit history queue + run counters) and queues them; a
// monitor pops one entry per clock and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_johnson_seq_checker;

  localparam int WIDTH      = 4;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_ERR = 4;
  localparam int ERR_W      = 8;
  localparam int CNT_MAX    = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  johnson_seq_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit err;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: last WIDTH valid bits (front = oldest), number of
  // valid bits seen (capped at WIDTH), run of matches, run of locked misses.
  bit   m_hist[$];
  int   m_seen, m_run, m_bad, m_cnt;
  bit   m_locked;

  int   vcount;        // valid bits since the last reset
  int   first_lock_v;  // valid-bit index at which locked was first seen
  int   err_idx[$];    // valid-bit indices of observed err pulses
  int   gen_pos;       // position in the generator stream

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit gen_bit(input int p);
    return (p % (2 * WIDTH)) >= WIDTH;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < WIDTH; i++) m_hist.push_back(1'b0);
    m_seen = 0; m_run = 0; m_bad = 0; m_cnt = 0; m_locked = 1'b0;
    vcount = 0; first_lock_v = -1;
    err_idx.delete();
    sb_q.delete();
  endtask

  task automatic model_step(input bit v, input bit d, input bit clr, output exp_t e);
    bit mis;
    bit pulse;
    pulse = 1'b0;
    if (v) begin
      mis = (d == m_hist[0]);
      if (m_seen < WIDTH) begin
        m_seen++;
      end else if (!m_locked) begin
        if (mis) m_run = 0;
        else begin
          m_run++;
          if (m_run == LOCK_CNT) begin m_locked = 1'b1; m_bad = 0; end
        end
      end else if (mis) begin
        pulse = 1'b1;
        m_bad++;
        if (m_bad == UNLOCK_ERR) begin m_locked = 1'b0; m_run = 0; end
      end else begin
        m_bad = 0;
      end
      void'(m_hist.pop_front());
      m_hist.push_back(d);
    end
    if (clr) m_cnt = 0;
    else if (pulse && m_cnt < CNT_MAX) m_cnt++;
    e.locked = m_locked;
    e.err    = pulse;
    e.cnt    = m_cnt;
  endtask

  // Drive one clock of stimulus and queue the expected post-edge outputs.
  task automatic step(input bit v, input bit d, input bit clr);
    exp_t e;
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr_cnt   = clr;
    model_step(v, d, clr, e);
    if (v) vcount++;
    sb_q.push_back(e);
  endtask

  task automatic send_stream(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, gen_bit(gen_pos), 1'b0);
      gen_pos++;
    end
  endtask

  // Let the last queued edge happen, then sit between edges.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Reset pulse inside one clock period, with outputs checked while asserted.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    #1;
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cnt"}, err_cnt, 0);
    model_reset();
    #3;
    rst = 1'b1;
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("mon_locked", locked, e.locked);
      check("mon_err", err, e.err);
      check("mon_cnt", err_cnt, e.cnt);
      if (locked === 1'b1 && first_lock_v < 0) first_lock_v = vcount;
      if (err === 1'b1) err_idx.push_back(vcount);
    end
  end

  initial begin
    model_reset();
    gen_pos = 0;

    // 1. Clean generator stream from reset.
    do_reset("rst0");
    gen_pos = 0;
    send_stream(200);
    settle();
    check("s1_lock_bit", first_lock_v, 12);
    check("s1_no_err", err_idx.size(), 0);
    check("s1_cnt", err_cnt, 0);

    // 2. Single flipped bit while locked.
    err_idx.delete();
    send_stream($urandom_range(0, 7));
    step(1'b1, ~gen_bit(gen_pos), 1'b0);
    gen_pos++;
    send_stream(12);
    settle();
    check("s2_pulses", err_idx.size(), 2);
    if (err_idx.size() == 2) check("s2_spacing", err_idx[1] - err_idx[0], 4);
    check("s2_cnt", err_cnt, 2);
    check("s2_locked", locked, 1);

    // 3. Random valid gaps from reset.
    do_reset("rst1");
    gen_pos = 0;
    for (int i = 0; i < 40; i++) begin
      int gaps;
      gaps = $urandom_range(1, 5);
      for (int g = 0; g < gaps; g++) step(1'b0, 1'($urandom), 1'b0);
      send_stream(1);
    end
    settle();
    check("s3_lock_bit", first_lock_v, 12);
    check("s3_no_err", err_idx.size(), 0);
    check("s3_cnt", err_cnt, 0);

    // 4. Stuck-at-zero while locked, then resume the stream.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      gen_pos++;
    end
    settle();
    check("s4_unlocked", locked, 0);
    check("s4_cnt", err_cnt, m_cnt);
    send_stream(30);
    settle();
    check("s4_relocked", locked, 1);

    // 5. Saturation: 300 mismatches, a match after every 3 keeps it locked.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, m_hist[0], 1'b0);
      if (i % 3 == 2) step(1'b1, ~m_hist[0], 1'b0);
    end
    settle();
    check("s5_sat", err_cnt, CNT_MAX);
    check("s5_locked", locked, 1);
    step(1'b1, m_hist[0], 1'b1);
    settle();
    check("s5_clr_cnt", err_cnt, 0);
    check("s5_clr_err", err, 1);

    // 6. Reset mid-lock; full re-lock needed afterwards.
    send_stream(40);
    settle();
    check("s6_pre_locked", locked, 1);
    do_reset("rst2");
    gen_pos = 0;
    send_stream(20);
    settle();
    check("s6_lock_bit", first_lock_v, 12);

    // 7. Random traffic: gaps, occasional flips, inverted phase, clears.
    do_reset("rst3");
    gen_pos = $urandom_range(0, 7);
    for (int i = 0; i < 400; i++) begin
      bit v, d, c;
      v = ($urandom_range(0, 9) != 0);
      d = gen_bit(gen_pos) ^ ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 49) == 0);
      step(v, d, c);
      if (v) gen_pos++;
    end
    settle();
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
